stream_merge_sorter: RTL and testbench
======================================

# stream_merge_sorter

Parametrised streaming sorter for signed samples. Each accepted input beat carries LANES samples and is sorted on entry; BLOCKS consecutive beats form one frame. The frame is then merged into a single sorted stream of LANES*BLOCKS samples, one sample per cycle. Two ping-pong banks let one frame fill while the previous frame drains. Valid/ready handshakes on both sides replace fixed-cadence input and output.

## Interface
- W, 8: sample width, two's-complement signed, ≥2
- LANES, 4: samples per input beat; one of 2, 4, 8
- BLOCKS, 8: beats per frame, 2..16
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*W  lane k at bits [k*W +: W]
- in_order  in  1  0 = descending, 1 = ascending; sampled with the first beat of a frame only
- out_valid  out  1  out_data holds a sample
- out_ready  in  1  sample consumed when out_valid && out_ready
- out_data  out  W  sorted sample, registered
- out_last  out  1  high with the final (LANES*BLOCKS-th) sample of a frame

## Operation
- Two banks, A and B. Each bank holds BLOCKS×LANES samples, one order bit, a beat counter, and BLOCKS head pointers of width clog2(LANES+1).
- Bank states are EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Fill side:
  - Writes go to the fill bank, which alternates A, B, A, ….
  - First accepted beat: EMPTY→FILLING and latch in_order.
  - BLOCKS-th accepted beat: FULL, then the fill pointer toggles.
  - in_ready = 1 iff the current fill bank is EMPTY or FILLING. This is combinational from registered state.
- Entry sort:
  - A combinational sorting network orders the LANES samples of each beat using the order bit in force for that frame. For the first beat, that is the live in_order.
  - The sorted beat is stored as block[beat_count].
- Drain side:
  - The drain bank alternates in the same order.
  - A FULL drain bank with an idle output stage becomes DRAINING.
  - Each output-stage load picks the best head among blocks whose pointer < LANES. "Best" is max for descending, min for ascending.
  - Ties go to the lowest block index. On a tie the sample is output once and only that block's pointer advances.
  - Exhausted blocks are excluded from selection.
- Output stage:
  - Loads when out_valid == 0 or out_ready == 1.
  - out_last is asserted on the final sample of the frame.
  - On the handshake of the out_last sample, the bank goes EMPTY, its pointers and counter clear, and the drain pointer toggles.
- Comparisons are signed in W bits; there is no widening and no saturation.
- Samples in a frame may be duplicated; every one of the LANES*BLOCKS samples is output exactly once.

## Timing
- Reset (async, rst = 0):
  - Both banks EMPTY, fill and drain pointers at A.
  - out_valid = 0, out_data = 0, out_last = 0.
  - in_ready = 1 once rst is released; its value while rst is low is don't-care.
- Latency:
  - BLOCKS-th beat accepted at edge t with an idle drain side: first out_valid at edge t+1.
  - With out_ready held high, one sample is output per cycle and out_last appears at edge t+LANES*BLOCKS.
- Throughput:
  - Input needs BLOCKS cycles per frame; output needs LANES*BLOCKS. The input is therefore back-pressured in steady state.
  - A third frame stalls (in_ready = 0) until a bank empties. in_ready rises the cycle after the out_last handshake.
- Simultaneous events:
  - The fill bank completing on the same edge the other bank finishes draining is legal. The new FULL bank starts draining on the next edge with no bubble beyond one cycle.
  - An out_ready low/high pattern never drops or repeats a sample. out_data is stable while out_valid && !out_ready.
- in_valid while in_ready = 0: the beat is ignored, and in_data may change freely.
- in_order is ignored on beats 2..BLOCKS of a frame.
- Reset mid-frame or mid-drain: all partial data is discarded and the block returns to reset values immediately.

## Test plan
- **Descending frame (defaults):**
  - Stimulus: in_order = 0, beats {3,-1,7,0}, {5,5,-8,2}, {127,-128,1,4}, {6,-3,9,-2}, {0,0,0,0}, {10,-10,11,-11}, {8,12,-5,13}, {2,1,-7,14}.
  - Required: 32 outputs, first 127, last -128, non-increasing order, out_last only on the 32nd.
- **Ascending order:**
  - Stimulus: same data with in_order = 1.
  - Required: first -128, last 127, non-decreasing order.
- **Order sampled once:** toggle in_order on beats 2..8 → order follows the beat-1 value only.
- **Ties / duplicates:** all 32 samples = 5 → 32 outputs of 5; the lowest block drains first (tracked through the pointer-advance sequence).
- **Output backpressure:**
  - Stimulus: out_ready pattern 1,0,0,1,0,1…
  - Required: the same output sequence as with out_ready held high, and out_data is stable while stalled.
- **Ping-pong and reset:**
  - Stimulus: 3 frames offered back-to-back.
  - Required: frame 2 is accepted immediately; frame 3 sees in_ready = 0 until frame 1's out_last handshake, then in_ready = 1 one cycle later.
  - Then rst low mid-drain → out_valid = 0 at once; the next frame sorts correctly.

Source files
------------

// File: rtl/stream_merge_sorter_if.sv
// Handshake bundle for stream_merge_sorter: beat input side and sample output side.
interface stream_merge_sorter_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned LANES = 4
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*W-1:0]     in_data;
   logic                   in_order;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [W-1:0]    out_data;
   logic                   out_last;

   // Producer/consumer side (testbench or upstream logic)
   modport master (
      output in_valid, in_data, in_order, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // Sorter side
   modport slave (
      input  in_valid, in_data, in_order, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/stream_merge_sorter.sv
// Streaming sorter: each beat is sorted on entry, BLOCKS beats form a frame,
// and the frame is merged out one sample per cycle from a ping-pong bank pair.
module stream_merge_sorter #(
   parameter int unsigned W      = 8,
   parameter int unsigned LANES  = 4,
   parameter int unsigned BLOCKS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   stream_merge_sorter_if.slave  bus
);
   localparam int unsigned TOTAL = LANES * BLOCKS;
   localparam int unsigned PW    = $clog2(LANES + 1);
   localparam int unsigned LW    = $clog2(LANES);
   localparam int unsigned CW    = $clog2(BLOCKS + 1);
   localparam int unsigned BW    = $clog2(BLOCKS);
   localparam int unsigned EW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FILLING  = 2'd1,
      ST_FULL     = 2'd2,
      ST_DRAINING = 2'd3
   } bank_st_e;

   bank_st_e            st_q    [2];
   bank_st_e            st_d    [2];
   logic                ord_q   [2];
   logic                ord_d   [2];
   logic [CW-1:0]       cnt_q   [2];
   logic [CW-1:0]       cnt_d   [2];
   logic [PW-1:0]       ptr_q   [2][BLOCKS];
   logic [PW-1:0]       ptr_d   [2][BLOCKS];
   logic signed [W-1:0] mem_q   [2][BLOCKS][LANES];
   logic                fill_q, fill_d;
   logic                drain_q, drain_d;
   logic [EW-1:0]       em_q, em_d;
   logic                out_valid_q, out_valid_d;
   logic signed [W-1:0] out_data_q, out_data_d;
   logic                out_last_q, out_last_d;

   logic                in_ready_c, acc_c, load_c, last_hs_c, ord_eff_c;
   logic signed [W-1:0] srt_c [LANES];
   logic signed [W-1:0] swp_c;
   logic                sel_ok_c;
   logic [BW-1:0]       sel_idx_c;
   logic signed [W-1:0] best_c, head_c;

   assign in_ready_c = (st_q[fill_q] == ST_EMPTY) || (st_q[fill_q] == ST_FILLING);
   assign acc_c      = bus.in_valid && in_ready_c;
   assign load_c     = !out_valid_q || bus.out_ready;
   assign last_hs_c  = out_valid_q && bus.out_ready && out_last_q;
   // The first beat of a frame sorts with the live order bit; later beats use the latched one.
   assign ord_eff_c  = (st_q[fill_q] == ST_EMPTY) ? bus.in_order : ord_q[fill_q];

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

   // Entry sort: odd-even transposition network over the lanes of one beat.
   always_comb begin
      swp_c = '0;
      for (int k = 0; k < LANES; k++) srt_c[k] = bus.in_data[k*W +: W];
      for (int p = 0; p < LANES; p++) begin
         for (int i = 0; i < LANES - 1; i++) begin
            if ((i % 2) == (p % 2)) begin
               if (ord_eff_c ? (srt_c[i] > srt_c[i+1]) : (srt_c[i] < srt_c[i+1])) begin
                  swp_c      = srt_c[i];
                  srt_c[i]   = srt_c[i+1];
                  srt_c[i+1] = swp_c;
               end
            end
         end
      end
   end

   // Merge select: best live head of the drain bank; strict compare keeps ties on the lowest block.
   always_comb begin
      sel_ok_c  = 1'b0;
      sel_idx_c = '0;
      best_c    = '0;
      head_c    = '0;
      if ((st_q[drain_q] == ST_FULL) || (st_q[drain_q] == ST_DRAINING)) begin
         for (int b = 0; b < BLOCKS; b++) begin
            if (ptr_q[drain_q][b] < PW'(LANES)) begin
               head_c = mem_q[drain_q][b][ptr_q[drain_q][b][LW-1:0]];
               if (!sel_ok_c || (ord_q[drain_q] ? (head_c < best_c) : (head_c > best_c))) begin
                  sel_ok_c  = 1'b1;
                  sel_idx_c = BW'(b);
                  best_c    = head_c;
               end
            end
         end
      end
   end

   // Bank state machines, pointers and output stage next-state.
   always_comb begin
      st_d        = st_q;
      ord_d       = ord_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      fill_d      = fill_q;
      drain_d     = drain_q;
      em_d        = em_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (acc_c) begin
         if (st_q[fill_q] == ST_EMPTY) begin
            st_d[fill_q]  = ST_FILLING;
            ord_d[fill_q] = bus.in_order;
         end
         cnt_d[fill_q] = cnt_q[fill_q] + CW'(1);
         if (cnt_q[fill_q] == CW'(BLOCKS - 1)) begin
            st_d[fill_q] = ST_FULL;
            fill_d       = ~fill_q;
         end
      end

      if (load_c) begin
         out_valid_d = sel_ok_c;
         out_last_d  = 1'b0;
         if (sel_ok_c) begin
            out_data_d                = best_c;
            out_last_d                = (em_q == EW'(TOTAL - 1));
            ptr_d[drain_q][sel_idx_c] = ptr_q[drain_q][sel_idx_c] + PW'(1);
            em_d                      = em_q + EW'(1);
            st_d[drain_q]             = ST_DRAINING;
         end
      end

      if (last_hs_c) begin
         st_d[drain_q]  = ST_EMPTY;
         cnt_d[drain_q] = '0;
         for (int b = 0; b < BLOCKS; b++) ptr_d[drain_q][b] = '0;
         em_d    = '0;
         drain_d = ~drain_q;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= ST_EMPTY;
            ord_q[i] <= 1'b0;
            cnt_q[i] <= '0;
            for (int b = 0; b < BLOCKS; b++) ptr_q[i][b] <= '0;
         end
         fill_q      <= 1'b0;
         drain_q     <= 1'b0;
         em_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         ord_q       <= ord_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         fill_q      <= fill_d;
         drain_q     <= drain_d;
         em_q        <= em_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Sample storage: the sorted beat lands in the next block slot of the fill bank.
   always_ff @(posedge clk) begin
      if (acc_c) begin
         for (int k = 0; k < LANES; k++) mem_q[fill_q][cnt_q[fill_q][BW-1:0]][k] <= srt_c[k];
      end
   end
endmodule

// File: tb/tb_stream_merge_sorter.sv
// Directed bench for stream_merge_sorter with hand-computed sorted frames.
module tb_stream_merge_sorter;
   localparam int unsigned W      = 8;
   localparam int unsigned LANES  = 4;
   localparam int unsigned BLOCKS = 8;
   localparam int unsigned TOTAL  = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stream_merge_sorter_if #(.W(W), .LANES(LANES)) bus ();
   stream_merge_sorter #(.W(W), .LANES(LANES), .BLOCKS(BLOCKS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int drain_bank = 0;

   int data_a [BLOCKS][LANES] = '{'{3, -1, 7, 0}, '{5, 5, -8, 2}, '{127, -128, 1, 4},
                                  '{6, -3, 9, -2}, '{0, 0, 0, 0}, '{10, -10, 11, -11},
                                  '{8, 12, -5, 13}, '{2, 1, -7, 14}};
   int exp_desc [TOTAL] = '{127, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 5, 4, 3, 2, 2,
                            1, 1, 0, 0, 0, 0, 0, -1, -2, -3, -5, -7, -8, -10, -11, -128};
   bit pat_bits [6] = '{1, 0, 0, 1, 0, 1};

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0 = descending data_a, 1 = ascending data_a, 2 = all fives
   function automatic int exp_at(input int mode, input int idx);
      if (mode == 0) return exp_desc[idx];
      if (mode == 1) return exp_desc[TOTAL-1-idx];
      return 5;
   endfunction

   // Offers one frame starting at a negedge; returns at the negedge after the last accept.
   task automatic send_frame(input int src, input bit ord, input bit tog,
                             output int stall, output time t_first);
      stall   = 0;
      t_first = 0;
      for (int b = 0; b < BLOCKS; b++) begin
         int k;
         bus.in_valid = 1'b1;
         for (int l = 0; l < LANES; l++)
            bus.in_data[l*W +: W] = (src == 1) ? W'(5) : W'(data_a[b][l]);
         bus.in_order = (tog && (b % 2 == 1)) ? !ord : ord;
         k = 0;
         while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
         end
         if (k >= 200) chk("in_ready_timeout", 0, 1);
         stall += k;
         if (b == 0) t_first = $time;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '1;
      bus.in_order = !ord;
   endtask

   // Consumes one frame with a given out_ready pattern and checks every sample.
   task automatic recv_frame(input int mode, input int pat, input int tie_bank,
                             output int first_k, output int last_k, output time t_last);
      int idx;
      bit held;
      int hv;
      idx = 0; held = 1'b0; hv = 0;
      first_k = -1; last_k = -1; t_last = 0;
      for (int c = 1; c <= 600 && idx < TOTAL; c++) begin
         @(negedge clk);
         if (held) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data", int'(bus.out_data), hv);
         end
         bus.out_ready = (pat == 0) ? 1'b1 : pat_bits[(c-1) % 6];
         held = 1'b0;
         if (bus.out_valid) begin
            if (first_k < 0) first_k = c;
            if (bus.out_ready) begin
               chk($sformatf("data[%0d]", idx), int'(bus.out_data), exp_at(mode, idx));
               chk($sformatf("last[%0d]", idx), int'(bus.out_last), (idx == TOTAL-1) ? 1 : 0);
               if (tie_bank >= 0)
                  chk($sformatf("tie_ptr[%0d]", idx), int'(dut.ptr_q[tie_bank][idx/LANES]),
                      idx % LANES + 1);
               if (bus.out_last) begin
                  last_k = c;
                  t_last = $time;
               end
               idx++;
            end else begin
               held = 1'b1;
               hv   = int'(bus.out_data);
            end
         end
      end
      if (idx < TOTAL) chk("recv_timeout", idx, TOTAL);
      bus.out_ready = 1'b1;
      drain_bank ^= 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  s1, s2, s3, fk, lk;
      time tf1, tf2, tf3, tl1, tl2, tl3;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_order  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);

      // Descending frame with latency checks
      send_frame(0, 1'b0, 1'b0, s1, tf1);
      chk("lat_not_yet_valid", int'(bus.out_valid), 0);
      recv_frame(0, 0, -1, fk, lk, tl1);
      chk("lat_first_valid", fk, 1);
      chk("lat_last", lk, TOTAL);

      // Ascending, then ascending with in_order toggled on later beats
      send_frame(0, 1'b1, 1'b0, s1, tf1);
      recv_frame(1, 0, -1, fk, lk, tl1);
      send_frame(0, 1'b1, 1'b1, s1, tf1);
      recv_frame(1, 0, -1, fk, lk, tl1);

      // All-equal frame: lowest block drains first
      send_frame(1, 1'b0, 1'b0, s1, tf1);
      recv_frame(2, 0, drain_bank, fk, lk, tl1);

      // Output backpressure
      send_frame(0, 1'b0, 1'b0, s1, tf1);
      recv_frame(0, 1, -1, fk, lk, tl1);

      // Ping-pong: three frames back to back
      fork
         begin
            send_frame(0, 1'b0, 1'b0, s1, tf1);
            send_frame(0, 1'b1, 1'b0, s2, tf2);
            send_frame(0, 1'b0, 1'b0, s3, tf3);
         end
         begin
            recv_frame(0, 0, -1, fk, lk, tl1);
            recv_frame(1, 0, -1, fk, lk, tl2);
            recv_frame(0, 0, -1, fk, lk, tl3);
         end
      join
      chk("pp_frame2_stall", s2, 0);
      chk("pp_frame3_stalled", (s3 > 0) ? 1 : 0, 1);
      chk("pp_frame3_ready_delay", int'(tf3 - tl1), 10);

      // Reset mid-drain, then a clean frame
      send_frame(0, 1'b0, 1'b0, s1, tf1);
      bus.out_ready = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("pre_rst_data[%0d]", c-1), int'(bus.out_data), exp_desc[c-1]);
      end
      chk("pre_rst_valid", int'(bus.out_valid), 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(bus.out_valid), 0);
      chk("mid_rst_out_data", int'(bus.out_data), 0);
      chk("mid_rst_out_last", int'(bus.out_last), 0);
      @(negedge clk);
      rst = 1'b1;
      drain_bank = 0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(bus.in_ready), 1);
      send_frame(0, 1'b1, 1'b0, s1, tf1);
      recv_frame(1, 0, -1, fk, lk, tl1);
      chk("post_rst_first", fk, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
